disp_bright: RTL and testbench

//  Brightness controller directly upstream of the display PDM dimmer; drives its 8-bit disp_pdm level.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/disp_bright_light_avg.sv | 44 ++++
 rtl/disp_bright.sv | 124 ++++++++++++
 tb/tb_disp_bright.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the display brightness controller.
// Holds the ramp FSM state encoding and the auto-mode clamp.
package disp_pkg;

  localparam int BR_LIGHT_W = 12;
  localparam int BR_PDM_W   = 8;

  typedef enum logic [1:0] {
    BR_HOLD = 2'd0,
    BR_UP   = 2'd1,
    BR_DOWN = 2'd2
  } br_state_t;

  // Lower clamp first, then upper, so an inverted window resolves to i_hi.
  function automatic logic [BR_PDM_W-1:0] br_clamp(
    input logic [BR_PDM_W-1:0] i_t,
    input logic [BR_PDM_W-1:0] i_lo,
    input logic [BR_PDM_W-1:0] i_hi
  );
    logic [BR_PDM_W-1:0] v;
    v = (i_t < i_lo) ? i_lo : i_t;
    v = (v > i_hi) ? i_hi : v;
    return v;
  endfunction

endpackage

// File: rtl/disp_bright_light_avg.sv
// Block averager for ambient-light samples: sums 2^AVG_LOG2 strobes and
// publishes the truncated mean; the wrap sample is folded into the result.
module light_avg
  import disp_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [BR_LIGHT_W-1:0] i_data,
  output logic [BR_LIGHT_W-1:0] o_avg
);

  localparam int ACC_W = BR_LIGHT_W + AVG_LOG2;

  logic [ACC_W-1:0]      r_acc;
  logic [AVG_LOG2-1:0]   r_cnt;
  logic [BR_LIGHT_W-1:0] r_avg;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_last;

  assign w_sum  = r_acc + ACC_W'(i_data);
  assign w_last = (r_cnt == {AVG_LOG2{1'b1}});
  assign o_avg  = r_avg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_avg <= '0;
    end else if (i_valid) begin
      if (w_last) begin
        r_avg <= w_sum[ACC_W-1:AVG_LOG2];
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_bright.sv
// Display brightness controller: forms a target from the light average or a
// manual value and slews disp_pdm toward it one LSB per ramp tick.
module disp_bright
  import disp_pkg::*;
#(
  parameter int                  RAMP_US   = 2000,
  parameter int                  AVG_LOG2  = 4,
  parameter logic [BR_PDM_W-1:0] PDM_RESET = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tsc_1ppus,
  input  logic                  light_valid,
  input  logic [BR_LIGHT_W-1:0] light_data,
  input  logic                  cfg_auto,
  input  logic [BR_PDM_W-1:0]   cfg_manual,
  input  logic [BR_PDM_W-1:0]   cfg_min,
  input  logic [BR_PDM_W-1:0]   cfg_max,
  output logic [BR_PDM_W-1:0]   disp_pdm,
  output logic [BR_LIGHT_W-1:0] light_avg,
  output logic                  ramping
);

  localparam int                DIV_W    = (RAMP_US > 1) ? $clog2(RAMP_US) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_US - 1);

  logic [BR_LIGHT_W-1:0] w_avg;
  logic [BR_PDM_W-1:0]   w_auto_t;
  logic [BR_PDM_W-1:0]   r_target;
  logic [DIV_W-1:0]      r_div;
  logic                  w_tick;
  br_state_t             r_state;
  br_state_t             w_state_next;
  logic [BR_PDM_W-1:0]   r_pdm;
  logic [BR_PDM_W-1:0]   w_pdm_next;
  logic                  r_ramping;

  light_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(light_valid),
    .i_data (light_data),
    .o_avg  (w_avg)
  );

  assign w_auto_t = br_clamp(w_avg[BR_LIGHT_W-1 -: BR_PDM_W], cfg_min, cfg_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= PDM_RESET;
    end else begin
      r_target <= cfg_auto ? w_auto_t : cfg_manual;
    end
  end

  // Free-running microsecond divider; target changes never resynchronise it.
  assign w_tick = tsc_1ppus && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (tsc_1ppus) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // A step always follows the current direction; the direction is then
  // re-judged against the post-step level so arrival and HOLD coincide.
  always_comb begin
    w_state_next = r_state;
    w_pdm_next   = r_pdm;
    unique case (r_state)
      BR_HOLD: begin
        if (r_target > r_pdm) begin
          w_state_next = BR_UP;
        end else if (r_target < r_pdm) begin
          w_state_next = BR_DOWN;
        end
      end
      BR_UP: begin
        if (w_tick && (r_pdm != {BR_PDM_W{1'b1}})) begin
          w_pdm_next = r_pdm + 1'b1;
        end
        if (w_pdm_next == r_target) begin
          w_state_next = BR_HOLD;
        end else if (w_pdm_next > r_target) begin
          w_state_next = BR_DOWN;
        end
      end
      BR_DOWN: begin
        if (w_tick && (r_pdm != {BR_PDM_W{1'b0}})) begin
          w_pdm_next = r_pdm - 1'b1;
        end
        if (w_pdm_next == r_target) begin
          w_state_next = BR_HOLD;
        end else if (w_pdm_next < r_target) begin
          w_state_next = BR_UP;
        end
      end
      default: begin
        w_state_next = BR_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BR_HOLD;
      r_pdm     <= PDM_RESET;
      r_ramping <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pdm     <= w_pdm_next;
      r_ramping <= (w_state_next != BR_HOLD);
    end
  end

  assign disp_pdm  = r_pdm;
  assign light_avg = w_avg;
  assign ramping   = r_ramping;

endmodule

// File: tb/tb_disp_bright.sv
// Directed bench for disp_bright with a short ramp period (4 us per step,
// 1 us = 4 clocks, so one step every 16 clocks).
module tb_disp_bright;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tsc_1ppus = 1'b0;
  logic        light_valid = 1'b0;
  logic [11:0] light_data = '0;
  logic        cfg_auto = 1'b0;
  logic [7:0]  cfg_manual = 8'h80;
  logic [7:0]  cfg_min = 8'h00;
  logic [7:0]  cfg_max = 8'hFF;
  logic [7:0]  disp_pdm;
  logic [11:0] light_avg;
  logic        ramping;

  int checks = 0;
  int errors = 0;

  disp_bright #(
    .RAMP_US  (4),
    .AVG_LOG2 (4),
    .PDM_RESET(8'h80)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tsc_1ppus  (tsc_1ppus),
    .light_valid(light_valid),
    .light_data (light_data),
    .cfg_auto   (cfg_auto),
    .cfg_manual (cfg_manual),
    .cfg_min    (cfg_min),
    .cfg_max    (cfg_max),
    .disp_pdm   (disp_pdm),
    .light_avg  (light_avg),
    .ramping    (ramping)
  );

  always #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      tsc_1ppus = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobes(input int n, input logic [11:0] d);
    for (int i = 0; i < n; i++) begin
      light_valid = 1'b1;
      light_data  = d;
      @(negedge clk);
    end
    light_valid = 1'b0;
  endtask

  task automatic wait_step(input int bound, output logic [7:0] val, output int n, output bit ok);
    logic [7:0] prev;
    prev = disp_pdm;
    ok = 1'b0;
    n = 0;
    while (n < bound && !ok) begin
      @(negedge clk);
      n++;
      if (disp_pdm !== prev) ok = 1'b1;
    end
    val = disp_pdm;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int n;
    n = 0;
    while (n < bound && ramping !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    ok = (ramping === 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] prev;
    int n;
    int bad;
    bit ok;

    // 1: reset and quiet manual hold
    cyc(3);
    check("rst_pdm", 32'(disp_pdm), 32'h80);
    check("rst_avg", 32'(light_avg), 32'h0);
    check("rst_ramping", 32'(ramping), 32'h0);
    rst_n = 1'b1;
    cyc(20);
    check("hold_pdm", 32'(disp_pdm), 32'h80);
    check("hold_ramping", 32'(ramping), 32'h0);

    // 2: manual ramp 0x80 -> 0x85
    cfg_manual = 8'h85;
    cyc(2);
    check("up_ramping", 32'(ramping), 32'h1);
    check("up_pdm_start", 32'(disp_pdm), 32'h80);
    for (int i = 0; i < 5; i++) begin
      wait_step(40, v, n, ok);
      check("up_step_seen", 32'(ok), 32'h1);
      check("up_step_val", 32'(v), 32'(8'h81 + i));
      if (i > 0) check("up_step_interval", 32'(n), 32'd16);
    end
    check("up_done_ramping", 32'(ramping), 32'h0);
    cyc(40);
    check("up_settled", 32'(disp_pdm), 32'h85);

    // 3: averager with back-to-back strobes across the wrap
    for (int i = 0; i < 32; i++) begin
      light_valid = 1'b1;
      light_data  = (i < 16) ? 12'h100 : 12'h7FF;
      @(negedge clk);
      if (i == 14) check("avg_partial", 32'(light_avg), 32'h0);
      if (i == 15) check("avg_first", 32'(light_avg), 32'h100);
    end
    light_valid = 1'b0;
    check("avg_second", 32'(light_avg), 32'h7FF);
    check("avg_manual_pdm", 32'(disp_pdm), 32'h85);

    // 4: auto clamps
    strobes(16, 12'hFFF);
    check("avg_full", 32'(light_avg), 32'hFFF);
    cfg_min  = 8'h00;
    cfg_max  = 8'hC0;
    cfg_auto = 1'b1;
    cyc(3);
    check("auto_hi_ramping", 32'(ramping), 32'h1);
    wait_idle(2000, ok);
    check("auto_hi_idle", 32'(ok), 32'h1);
    check("auto_hi_pdm", 32'(disp_pdm), 32'hC0);
    cfg_min = 8'hD0;
    cyc(40);
    check("auto_inv_pdm", 32'(disp_pdm), 32'hC0);
    check("auto_inv_ramping", 32'(ramping), 32'h0);
    strobes(16, 12'h000);
    check("avg_dark", 32'(light_avg), 32'h0);
    cyc(20);
    check("dark_inv_pdm", 32'(disp_pdm), 32'hC0);
    cfg_min = 8'h10;
    cfg_max = 8'hFF;
    cyc(3);
    check("auto_lo_ramping", 32'(ramping), 32'h1);
    wait_idle(4000, ok);
    check("auto_lo_idle", 32'(ok), 32'h1);
    check("auto_lo_pdm", 32'(disp_pdm), 32'h10);

    // 5: reversal mid-ramp, down to 0 without wrap
    cfg_auto   = 1'b0;
    cfg_manual = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      wait_step(40, v, n, ok);
      check("rev_up_val", 32'(v), 32'(8'h11 + i));
    end
    cfg_manual = 8'h00;
    wait_step(40, v, n, ok);
    check("rev_first_down", 32'(v), 32'h13);
    bad = 0;
    prev = v;
    while (prev != 8'h00 && bad == 0) begin
      wait_step(40, v, n, ok);
      if (!ok || v != prev - 8'd1) bad++;
      prev = v;
    end
    check("rev_monotonic", 32'(bad), 32'h0);
    check("rev_end_pdm", 32'(disp_pdm), 32'h0);
    check("rev_end_ramping", 32'(ramping), 32'h0);
    cyc(60);
    check("rev_no_wrap", 32'(disp_pdm), 32'h0);

    // 6: async reset mid-ramp and mid-average
    cfg_manual = 8'h40;
    strobes(16, 12'h200);
    check("pre_rst_avg", 32'(light_avg), 32'h200);
    strobes(8, 12'hFFF);
    check("pre_rst_ramping", 32'(ramping), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pdm", 32'(disp_pdm), 32'h80);
    check("arst_avg", 32'(light_avg), 32'h0);
    check("arst_ramping", 32'(ramping), 32'h0);
    cfg_manual = 8'h80;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    strobes(8, 12'h100);
    check("post_rst_partial", 32'(light_avg), 32'h0);
    strobes(8, 12'h100);
    check("post_rst_avg", 32'(light_avg), 32'h100);
    check("post_rst_pdm", 32'(disp_pdm), 32'h80);
    check("post_rst_ramping", 32'(ramping), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
